// File: rtl/reinyector.sv
// Reinjector: merges recirculated and fresh words per lane, buffering recirculated words that lose the output slot.
// Optional macro REINYECTOR_OVF_EN enables the sticky error_ovf flag; otherwise error_ovf is tied to 0.

module reinyector_lane #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_i,
  input  logic       rc_vld_i,
  input  logic [7:0] rc_data_i,
  input  logic       nw_vld_i,
  input  logic [7:0] nw_data_i,
  output logic       out_vld_o,
  output logic [7:0] out_data_o,
  output logic       stall_o,
  output logic       fifo_ne_o,
  output logic       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          adv, ne, full, pop, byp, push, wr_en;

  assign adv   = ready_i | ~vld_q;
  assign ne    = (cnt_q != '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = adv & ne;
  assign byp   = adv & ~ne & rc_vld_i;
  // A recirculated word that cannot take the output slot must be buffered.
  assign push  = rc_vld_i & ~byp;
  assign wr_en = push & (~full | pop);
  assign ovf_o = push & full & ~pop;

  assign stall_o    = ~reset & (~adv | ne | rc_vld_i);
  assign fifo_ne_o  = ne;
  assign out_vld_o  = vld_q;
  assign out_data_o = data_q;

  always_comb begin
    wr_d   = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
    data_d = data_q;
    vld_d  = vld_q;
    if (adv) begin
      vld_d = 1'b1;
      if (pop)           data_d = mem_q[rd_q];
      else if (rc_vld_i) data_d = rc_data_i;
      else if (nw_vld_i) data_d = nw_data_i;
      else               vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= rc_data_i;
  end
endmodule

module reinyector #(
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dataRecirc0,
  input  logic [7:0] dataRecirc1,
  input  logic [7:0] dataRecirc2,
  input  logic [7:0] dataRecirc3,
  input  logic       validRecirc0,
  input  logic       validRecirc1,
  input  logic       validRecirc2,
  input  logic       validRecirc3,
  input  logic [7:0] dataNew0,
  input  logic [7:0] dataNew1,
  input  logic [7:0] dataNew2,
  input  logic [7:0] dataNew3,
  input  logic       validNew0,
  input  logic       validNew1,
  input  logic       validNew2,
  input  logic       validNew3,
  input  logic       readyOut,
  output logic       stallNew0,
  output logic       stallNew1,
  output logic       stallNew2,
  output logic       stallNew3,
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic [7:0] dataOut2,
  output logic [7:0] dataOut3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3,
  output logic       selector_IDLE,
  output logic       error_ovf
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int QW        = 4;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  logic [NUM_LANES-1:0][VEC_W-1:0] rc_data, nw_data, out_data;
  logic [NUM_LANES-1:0]            rc_vld, nw_vld, out_vld, stall, fifo_ne, ovf;
  state_e                          state_q, state_d;
  logic [QW-1:0]                   qcnt_q, qcnt_d;
  logic                            quiet, start;

  assign rc_data = {dataRecirc3, dataRecirc2, dataRecirc1, dataRecirc0};
  assign rc_vld  = {validRecirc3, validRecirc2, validRecirc1, validRecirc0};
  assign nw_data = {dataNew3, dataNew2, dataNew1, dataNew0};
  assign nw_vld  = {validNew3, validNew2, validNew1, validNew0};

  assign {dataOut3, dataOut2, dataOut1, dataOut0}     = out_data;
  assign {validOut3, validOut2, validOut1, validOut0} = out_vld;
  assign {stallNew3, stallNew2, stallNew1, stallNew0} = stall;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    reinyector_lane #(.DEPTH(FIFO_DEPTH)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .ready_i   (readyOut),
      .rc_vld_i  (rc_vld[l]),
      .rc_data_i (rc_data[l]),
      .nw_vld_i  (nw_vld[l]),
      .nw_data_i (nw_data[l]),
      .out_vld_o (out_vld[l]),
      .out_data_o(out_data[l]),
      .stall_o   (stall[l]),
      .fifo_ne_o (fifo_ne[l]),
      .ovf_o     (ovf[l])
    );
  end

  assign quiet = ~|{fifo_ne, rc_vld, nw_vld, out_vld};
  assign start = |rc_vld | |(nw_vld & ~stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = '0;
    case (state_q)
      IDLE:   if (start) state_d = ACTIVE;
      ACTIVE: begin
        // The edge that would bring the count to IDLE_CYCLES is the one that drops to IDLE.
        if (quiet) begin
          if (qcnt_q == QW'(IDLE_CYCLES - 1)) state_d = IDLE;
          else                                qcnt_d  = qcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    selector_IDLE = (state_q == IDLE);
  end

`ifdef REINYECTOR_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (reset)     ovf_q <= 1'b0;
    else if (|ovf) ovf_q <= 1'b1;
  end
  assign error_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = |ovf;
  assign error_ovf  = 1'b0;
`endif
endmodule

// File: doc/reinyector.md
REINYECTOR -- requirements
Module: reinyector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, gives the number of recirculated-word entries buffered per lane (power of two, 2..16).
REQ-002 Parameter IDLE_CYCLES, default 4, gives the number of consecutive quiet cycles before returning to IDLE (1..15).
REQ-003 Port clk, input, 1, is the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Ports dataRecirc0..3, input, 8 each, carry the recirculated words returned by the recirculator lanes.
REQ-006 Ports validRecirc0..3, input, 1 each, qualify dataRecirc0..3.
REQ-007 Ports dataNew0..3, input, 8 each, carry fresh words from the upstream source.
REQ-008 Ports validNew0..3, input, 1 each, qualify dataNew0..3.
REQ-009 Port readyOut, input, 1, is the downstream ready, shared by all lanes.
REQ-010 Ports stallNew0..3, output, 1 each, are combinational backpressure to the fresh source; a stalled word SHALL be held by the source.
REQ-011 Ports dataOut0..3, output, 8 each, are registered merged words for the recirculator inputs.
REQ-012 Ports validOut0..3, output, 1 each, are registered qualifiers for dataOut0..3.
REQ-013 Port selector_IDLE, output, 1, is registered and drives the recirculator selector; it is 1 in state IDLE.
REQ-014 Port error_ovf, output, 1, is the sticky overflow flag (see Configuration).

Function
REQ-015 Per lane i, adv_i = readyOut | ~validOut_i; a transfer occurs when validOut_i & readyOut.
REQ-016 When adv_i=1, the output register SHALL load from exactly one source in this priority order: FIFO head (popped), then dataRecirc_i if validRecirc_i (bypass), then dataNew_i if validNew_i; with no source, validOut_i<=0 and dataOut_i holds its value.
REQ-017 When adv_i=0, dataOut_i and validOut_i SHALL hold.
REQ-018 A valid recirculated word not loaded into the output register SHALL be pushed into lane i's FIFO in the same cycle.
REQ-019 stallNew_i = ~adv_i | fifo_nonempty_i | validRecirc_i; a fresh word is accepted only when validNew_i & ~stallNew_i.
REQ-020 Latency from an accepted input to validOut SHALL be 1 cycle; FIFO order SHALL be strict first-in first-out.
REQ-021 Push and pop in the same cycle on a full FIFO SHALL succeed with the occupancy unchanged.
REQ-022 A push to a full FIFO without a pop SHALL drop the word, leave FIFO contents unchanged, and raise the overflow event.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-024 The FSM SHALL have two states, IDLE and ACTIVE; IDLE->ACTIVE occurs on any validRecirc_i or accepted validNew_i.
REQ-025 In ACTIVE, a quiet cycle (all FIFOs empty, no validRecirc, no validNew, no validOut) increments a counter; any non-quiet cycle clears it.
REQ-026 ACTIVE->IDLE SHALL occur on the cycle the counter reaches IDLE_CYCLES; selector_IDLE updates on the same edge as the state.
REQ-027 Lanes SHALL be independent except for the shared readyOut and the FSM.

Reset
REQ-028 On reset=1 at a clock edge: all FIFOs are emptied, dataOut0..3=0, validOut0..3=0, state=IDLE, selector_IDLE=1, quiet counter=0, error_ovf=0.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight words, with no output pulse on the following cycle.
REQ-030 stallNew0..3 SHALL equal 0 during reset.

Configuration
REQ-031 With macro REINYECTOR_OVF_EN defined, error_ovf SHALL set on any overflow event and clear only on reset.
REQ-032 Without REINYECTOR_OVF_EN, error_ovf SHALL be constant 0; overflowing words are still dropped silently.

Verification
REQ-033 Bench: after reset, validNew0=1 with dataNew0=0x5A and readyOut=1 -> dataOut0=0x5A, validOut0=1 one cycle later; stallNew0=0; selector_IDLE 1->0.
REQ-034 Bench: validRecirc1=1 with 0x11 and validNew1=1 with 0x22 in the same cycle -> 0x11 output first, stallNew1=1 that cycle; 0x22 output on the next cycle.
REQ-035 Bench: readyOut=0 for 5 cycles while lane 2 receives recirculated words 0x01..0x05 with FIFO_DEPTH=4 -> one word stored in the output register, 4 in the FIFO, none dropped; after readyOut=1, outputs are 0x01..0x05 in order.
REQ-036 Bench: readyOut=0 while 6 recirculated words arrive on lane 3 -> the 6th word (0x06) is dropped and error_ovf=1 (with the macro) or 0 (without it); after reset, error_ovf=0.
REQ-037 Bench: after the last transfer with all inputs idle -> selector_IDLE returns to 1 exactly IDLE_CYCLES=4 quiet cycles later; a validNew at quiet cycle 3 restarts the count.
REQ-038 Bench: assert reset while lane 0 FIFO holds 3 words -> on the next cycle validOut0=0, FIFO empty, selector_IDLE=1.
